mem_wb_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline latch of the multicore pipeline.
- Consumes the EX/MEM latch outputs and drives the data-cache request (dmemREN/dmemWEN).
- Sequences each access to dhit, implements the LL/SC link register with coherence-snoop invalidation, and registers writeback fields for the WB stage.
- Generates mem_stall to the hazard unit while an access is outstanding.

---
 rtl/mem_wb_stage.sv | 159 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB latch: sequences each data-cache access to dhit,
// keeps the LL/SC link register coherent with snoops, and registers WB fields.
module mem_wb_stage #(
  parameter int WORD_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              advance,
  input  logic              flush,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_ll,
  input  logic              ex_sc,
  input  logic [WORD_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_store,
  input  logic              ex_RegWr,
  input  logic [SEL_W-1:0]  ex_wsel,
  input  logic              ex_MemtoReg,
  input  logic              ex_JAL,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic              ex_halt,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              wb_RegWr,
  output logic [SEL_W-1:0]  wb_wsel,
  output logic              wb_MemtoReg,
  output logic              wb_JAL,
  output logic              wb_halt,
  output logic [WORD_W-1:0] wb_alu,
  output logic [WORD_W-1:0] wb_mem,
  output logic [WORD_W-1:0] wb_npc
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic              regwr;
    logic [SEL_W-1:0]  wsel;
    logic              memtoreg;
    logic              jal;
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] mem;
    logic [WORD_W-1:0] npc;
  } wb_t;

  state_t              state, state_n;
  logic                link_valid;
  logic [WORD_W-3:0]   link_addr;
  logic [WORD_W-1:0]   buf_q;
  wb_t                 wb_q, wb_d;
  logic                halt_q;

  logic                op, link_hit, snoop_hit, sc_fail, reqphase;
  logic                first_done, done_now, capture, latch_en;
  logic [WORD_W-1:0]   cap_val, mem_data;
  logic                unused_lowbits;

  assign unused_lowbits = ^{ex_addr[1:0], snoop_addr[1:0]};

  assign op        = ex_dREN | ex_dWEN;
  assign link_hit  = link_valid & (link_addr == ex_addr[WORD_W-1:2]);
  assign snoop_hit = snoop_inv & link_valid & (snoop_addr[WORD_W-1:2] == link_addr);
  // SC outcome is decided only in IDLE; once in WAIT the store is committed.
  assign sc_fail   = ex_sc & ~link_hit & (state == IDLE);
  assign reqphase  = (state == IDLE) | (state == WAIT);

  assign first_done = (state == IDLE) & op & (dhit | sc_fail);
  assign done_now   = first_done | ((state == WAIT) & dhit);
  assign capture    = done_now & (ex_dREN | ex_sc);
  assign cap_val    = ex_sc ? {{(WORD_W-1){1'b0}}, ~sc_fail} : dmemload;
  // A same-cycle completion must forward the captured value into the latch.
  assign mem_data   = capture ? cap_val : buf_q;
  assign latch_en   = advance & ~mem_stall;

  assign dmemaddr  = ex_addr;
  assign dmemstore = ex_store;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_n;
  end

  // A completion that advances in the same cycle has already left; skip DONE.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (first_done)  state_n = advance ? IDLE : DONE;
        else if (op)     state_n = WAIT;
      end
      WAIT: if (dhit)    state_n = DONE;
      DONE: if (advance) state_n = IDLE;
      default:           state_n = IDLE;
    endcase
  end

  // Requests are gated by nRST so they drop while reset is held.
  always_comb begin
    dmemREN   = nRST & ex_dREN & reqphase;
    dmemWEN   = nRST & ex_dWEN & reqphase & ~sc_fail;
    mem_stall = nRST & op & reqphase & ~first_done;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (done_now & ex_ll) begin
      link_valid <= 1'b1;
      link_addr  <= ex_addr[WORD_W-1:2];
    end else if ((done_now & ex_sc) | snoop_hit) begin
      link_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        buf_q <= '0;
    else if (capture) buf_q <= cap_val;
  end

  always_comb begin
    wb_d          = '0;
    wb_d.regwr    = ex_RegWr;
    wb_d.wsel     = ex_wsel;
    wb_d.memtoreg = ex_MemtoReg;
    wb_d.jal      = ex_JAL;
    wb_d.alu      = ex_addr;
    wb_d.mem      = op ? mem_data : '0;
    wb_d.npc      = ex_npc;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_q   <= '0;
      halt_q <= 1'b0;
    end else if (latch_en) begin
      wb_q   <= flush ? '0 : wb_d;
      halt_q <= halt_q | (~flush & ex_halt);
    end
  end

  assign wb_RegWr    = wb_q.regwr;
  assign wb_wsel     = wb_q.wsel;
  assign wb_MemtoReg = wb_q.memtoreg;
  assign wb_JAL      = wb_q.jal;
  assign wb_alu      = wb_q.alu;
  assign wb_mem      = wb_q.mem;
  assign wb_npc      = wb_q.npc;
  assign wb_halt     = halt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: per-instruction reference model (link register, data
// buffer, sticky halt) drives randomized accesses, snoops, stalls and flushes.
module tb_mem_wb_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        advance, flush, ex_dREN, ex_dWEN, ex_ll, ex_sc;
  logic [31:0] ex_addr, ex_store, ex_npc;
  logic        ex_RegWr, ex_MemtoReg, ex_JAL, ex_halt;
  logic [4:0]  ex_wsel;
  logic        dhit, snoop_inv;
  logic [31:0] dmemload, snoop_addr;
  logic        dmemREN, dmemWEN, mem_stall;
  logic [31:0] dmemaddr, dmemstore;
  logic        wb_RegWr, wb_MemtoReg, wb_JAL, wb_halt;
  logic [4:0]  wb_wsel;
  logic [31:0] wb_alu, wb_mem, wb_npc;

  mem_wb_stage #(.WORD_W(32), .SEL_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .advance(advance), .flush(flush),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_ll(ex_ll), .ex_sc(ex_sc),
    .ex_addr(ex_addr), .ex_store(ex_store), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
    .ex_MemtoReg(ex_MemtoReg), .ex_JAL(ex_JAL), .ex_npc(ex_npc), .ex_halt(ex_halt),
    .dhit(dhit), .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_RegWr(wb_RegWr), .wb_wsel(wb_wsel),
    .wb_MemtoReg(wb_MemtoReg), .wb_JAL(wb_JAL), .wb_halt(wb_halt),
    .wb_alu(wb_alu), .wb_mem(wb_mem), .wb_npc(wb_npc)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic        lv_m;
  logic [29:0] la_m;
  logic [31:0] buf_m;
  logic        halt_m;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_LL = 3, K_SC = 4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_ex();
    ex_dREN = 0; ex_dWEN = 0; ex_ll = 0; ex_sc = 0;
    ex_addr = 0; ex_store = 0; ex_RegWr = 0; ex_wsel = 0;
    ex_MemtoReg = 0; ex_JAL = 0; ex_npc = 0; ex_halt = 0;
  endtask

  // One instruction through MEM: lat = cycles before dhit (0 = same-cycle hit),
  // fl = forced flush value or -1 for random, adv_hi holds advance high.
  task automatic run_op(input int kind, input logic [31:0] addr, input int lat,
                        input int fl, input bit adv_hi, input bit sn,
                        input logic [31:0] sn_addr);
    logic [31:0] ld, st, npc, exp_mem;
    logic        rw, m2r, jal, hlt, fnow, retire;
    logic [4:0]  ws;
    bit          dren, dwen, scf, req, done;
    int          ready;
    ld  = $urandom; st = $urandom; npc = $urandom;
    rw  = 1'($urandom); m2r = 1'($urandom); jal = 1'($urandom);
    ws  = 5'($urandom); hlt = ($urandom_range(0, 19) == 0);
    dren = (kind == K_LW) || (kind == K_LL);
    dwen = (kind == K_SW) || (kind == K_SC);
    ex_dREN = dren; ex_dWEN = dwen; ex_ll = (kind == K_LL); ex_sc = (kind == K_SC);
    ex_addr = addr; ex_store = st; ex_RegWr = rw; ex_wsel = ws;
    ex_MemtoReg = m2r; ex_JAL = jal; ex_npc = npc; ex_halt = hlt;
    scf   = (kind == K_SC) && !(lv_m && la_m == addr[31:2]);
    req   = (kind != K_ALU) && !scf;
    ready = (req && lat > 0) ? lat + 1 : 0;
    done  = 0;
    fnow  = 0;
    for (int c = 0; c <= 40 && !done; c++) begin
      dhit       = req && c == lat;
      dmemload   = dhit ? ld : $urandom;
      if (adv_hi)          advance = 1;
      else if (c >= ready) advance = ($urandom_range(0, 3) != 0) || (c > ready + 6);
      else                 advance = 1'($urandom);
      flush      = (fl >= 0) ? fl[0] : ($urandom_range(0, 5) == 0);
      snoop_inv  = sn && c == 0;
      snoop_addr = sn_addr;
      @(negedge CLK);
      chk("dmemREN", {31'b0, dmemREN}, {31'b0, dren && req && c <= lat});
      chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, dwen && req && c <= lat});
      chk("mem_stall", {31'b0, mem_stall}, {31'b0, req && lat > 0 && c <= lat});
      if (c == 0) begin
        chk("dmemaddr", dmemaddr, addr);
        chk("dmemstore", dmemstore, st);
      end
      retire = advance && c >= ready;
      fnow   = flush;
      @(posedge CLK); #1;
      snoop_inv = 0;
      dhit      = 0;
      if (retire) done = 1;
    end
    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
    end else begin
      if (dren) buf_m = ld;
      if (kind == K_SC) buf_m = scf ? 32'd0 : 32'd1;
      if (kind == K_LL) begin lv_m = 1; la_m = addr[31:2]; end
      if (kind == K_SC) lv_m = 0;
      if (!fnow) halt_m = halt_m | hlt;
      exp_mem = (kind != K_ALU) ? buf_m : 32'd0;
      chk("wb_RegWr", {31'b0, wb_RegWr}, fnow ? 32'd0 : {31'b0, rw});
      chk("wb_wsel", {27'b0, wb_wsel}, fnow ? 32'd0 : {27'b0, ws});
      chk("wb_MemtoReg", {31'b0, wb_MemtoReg}, fnow ? 32'd0 : {31'b0, m2r});
      chk("wb_JAL", {31'b0, wb_JAL}, fnow ? 32'd0 : {31'b0, jal});
      chk("wb_alu", wb_alu, fnow ? 32'd0 : addr);
      chk("wb_mem", wb_mem, fnow ? 32'd0 : exp_mem);
      chk("wb_npc", wb_npc, fnow ? 32'd0 : npc);
      chk("wb_halt", {31'b0, wb_halt}, {31'b0, halt_m});
    end
    if (sn && lv_m && la_m == sn_addr[31:2]) lv_m = 0;
    clear_ex();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] pool [4];
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300; pool[3] = 32'h304;
    return pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    int k;
    nRST = 0; advance = 0; flush = 0; dhit = 0; dmemload = 0;
    snoop_inv = 0; snoop_addr = 0;
    clear_ex();
    lv_m = 0; la_m = 0; buf_m = 0; halt_m = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_wb_RegWr", {31'b0, wb_RegWr}, 32'd0);
    chk("rst_wb_mem", wb_mem, 32'd0);
    chk("rst_wb_halt", {31'b0, wb_halt}, 32'd0);
    chk("rst_dmemREN", {31'b0, dmemREN}, 32'd0);
    @(negedge CLK) nRST = 1;
    @(posedge CLK); #1;

    // directed cases
    run_op(K_LW, 32'h100, 2, 0, 0, 0, 0);   // dhit on third request cycle
    run_op(K_SW, 32'h200, 0, 0, 1, 0, 0);   // same-cycle hit, no stall
    run_op(K_LL, 32'h300, 0, 0, 1, 0, 0);
    run_op(K_SC, 32'h300, 1, 0, 0, 0, 0);   // link valid: succeeds
    run_op(K_SC, 32'h300, 0, 0, 1, 0, 0);   // link consumed: fails
    run_op(K_LL, 32'h300, 1, 0, 1, 0, 0);
    run_op(K_ALU, 32'h0, 0, 0, 1, 1, 32'h300);
    run_op(K_SC, 32'h300, 0, 0, 1, 0, 0);   // snooped away: fails
    run_op(K_LW, 32'h100, 3, 1, 1, 0, 0);   // flush during WAIT -> bubble

    // randomized mix
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 4);
      run_op(k, pick_addr(), $urandom_range(0, 3), -1, 0,
             (k == K_ALU) && ($urandom_range(0, 1) == 1), pick_addr());
    end

    // reset in the middle of a WAIT
    run_op(K_LL, 32'h300, 0, 0, 1, 0, 0);
    ex_dREN = 1; ex_addr = 32'h100; ex_RegWr = 1; advance = 1; dhit = 0;
    @(posedge CLK); #1;
    chk("wait_dmemREN", {31'b0, dmemREN}, 32'd1);
    #1 nRST = 0;
    #1;
    chk("arst_dmemREN", {31'b0, dmemREN}, 32'd0);
    chk("arst_stall", {31'b0, mem_stall}, 32'd0);
    chk("arst_wb_RegWr", {31'b0, wb_RegWr}, 32'd0);
    chk("arst_wb_alu", wb_alu, 32'd0);
    chk("arst_wb_mem", wb_mem, 32'd0);
    chk("arst_wb_halt", {31'b0, wb_halt}, 32'd0);
    clear_ex();
    lv_m = 0; la_m = 0; buf_m = 0; halt_m = 0;
    @(negedge CLK) nRST = 1;
    @(posedge CLK); #1;
    run_op(K_SC, 32'h300, 0, 0, 1, 0, 0);   // link cleared by reset
    run_op(K_LW, 32'h100, 1, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
